fetch_ctrl: RTL and testbench

- Sequencing controller for the fetch unit.
- Drives the PC-select (Asel) and PC-enable controls, supplies the registered branch address, and gates the IF/ID and ID/EX pipeline registers.
- Arbitrates between three events: a branch redirect from EX, a load-use stall from decode, and instruction-memory wait states.
- Provides a wait-state timeout and a bubble performance counter.

---
 rtl/fetch_ctrl_if.sv | 38 +++
 rtl/fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Fetch-controller bundle: hazard/redirect/imem inputs, PC and
//            pipeline-register controls out.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
);
    logic             imem_ready;
    logic             stall_dec;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             imem_req;
    logic             pc_en;
    logic             pc_sel;
    logic [WIDTH-1:0] branch_address;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             fetch_err;
    logic [CNTW-1:0]  bubble_cnt;

    modport master (
        input  imem_ready, stall_dec, br_taken, br_target,
        output imem_req, pc_en, pc_sel, branch_address,
               ifid_en, ifid_flush, idex_flush, fetch_err, bubble_cnt
    );

    modport slave (
        output imem_ready, stall_dec, br_taken, br_target,
        input  imem_req, pc_en, pc_sel, branch_address,
               ifid_en, ifid_flush, idex_flush, fetch_err, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Fetch sequencing FSM arbitrating branch redirect, load-use stall
//            and imem wait states; wait timeout and bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int WIDTH    = 32,
    parameter int BOOT_CYC = 2,
    parameter int WAIT_MAX = 15,
    parameter int CNTW     = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fetch_ctrl_if.master     bus
);
    localparam int BCW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam int WCW = $clog2(WAIT_MAX + 1);

    localparam logic [BCW-1:0]  c_BOOT_LAST = BCW'(BOOT_CYC - 1);
    localparam logic [WCW-1:0]  c_WAIT_MAX  = WCW'(WAIT_MAX);
    localparam logic [CNTW-1:0] c_BUB_MAX   = '1;

    localparam logic [2:0] c_ST_BOOT  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_REDIR = 3'd3;
    localparam logic [2:0] c_ST_HALT  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [BCW-1:0]   boot_cnt_q, boot_cnt_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] baddr_q, baddr_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  bub_q, bub_d;
    logic [WCW-1:0]   w_wait_inc;

    logic w_req, w_pc_en, w_pc_sel, w_ifid_en, w_ifid_flush, w_idex_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_ST_BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            baddr_q    <= '0;
            err_q      <= 1'b0;
            bub_q      <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            baddr_q    <= baddr_d;
            err_q      <= err_d;
            bub_q      <= bub_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        baddr_d    = baddr_q;
        w_wait_inc = wait_cnt_q + 1'b1;
        case (state_q)
            c_ST_BOOT: begin
                if (boot_cnt_q == c_BOOT_LAST) state_d = c_ST_FETCH;
                else                           boot_cnt_d = boot_cnt_q + 1'b1;
            end
            c_ST_FETCH, c_ST_WAIT: begin
                if (bus.br_taken) begin
                    baddr_d = bus.br_target;
                    state_d = c_ST_REDIR;
                end else if (bus.stall_dec) begin
                    // Stall holds the timeout count unless memory answered.
                    if (bus.imem_ready) wait_cnt_d = '0;
                end else if (bus.imem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = c_ST_FETCH;
                end else begin
                    wait_cnt_d = w_wait_inc;
                    state_d    = (w_wait_inc == c_WAIT_MAX) ? c_ST_HALT : c_ST_WAIT;
                end
            end
            c_ST_REDIR: begin
                wait_cnt_d = '0;
                if (bus.br_taken) begin
                    baddr_d = bus.br_target;
                    state_d = c_ST_REDIR;
                end else begin
                    state_d = c_ST_FETCH;
                end
            end
            c_ST_HALT: state_d = c_ST_HALT;
            default:   state_d = c_ST_BOOT;
        endcase
        err_d = err_q | (state_d == c_ST_HALT);
        bub_d = (w_ifid_flush && (bub_q != c_BUB_MAX)) ? bub_q + 1'b1 : bub_q;
    end

    always_comb begin
        w_req        = 1'b0;
        w_pc_en      = 1'b0;
        w_pc_sel     = 1'b0;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        case (state_q)
            c_ST_BOOT: w_ifid_flush = 1'b1;
            c_ST_FETCH, c_ST_WAIT: begin
                if (bus.br_taken) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (bus.stall_dec) begin
                    w_req = 1'b1;
                end else if (bus.imem_ready) begin
                    w_req     = 1'b1;
                    w_pc_en   = 1'b1;
                    w_ifid_en = 1'b1;
                end else begin
                    w_req        = 1'b1;
                    w_ifid_en    = 1'b1;
                    w_ifid_flush = 1'b1;
                end
            end
            c_ST_REDIR: begin
                w_pc_sel     = 1'b1;
                w_pc_en      = 1'b1;
                w_ifid_en    = 1'b1;
                w_ifid_flush = 1'b1;
                w_idex_flush = bus.br_taken;
            end
            c_ST_HALT: w_ifid_flush = 1'b1;
            default:   w_ifid_flush = 1'b0;
        endcase
        // Controls read as zero while reset is held, not just after the edge.
        if (!rst_n) begin
            w_req        = 1'b0;
            w_pc_en      = 1'b0;
            w_pc_sel     = 1'b0;
            w_ifid_en    = 1'b0;
            w_ifid_flush = 1'b0;
            w_idex_flush = 1'b0;
        end
    end

    assign bus.imem_req       = w_req;
    assign bus.pc_en          = w_pc_en;
    assign bus.pc_sel         = w_pc_sel;
    assign bus.ifid_en        = w_ifid_en;
    assign bus.ifid_flush     = w_ifid_flush;
    assign bus.idex_flush     = w_idex_flush;
    assign bus.branch_address = baddr_q;
    assign bus.fetch_err      = err_q;
    assign bus.bubble_cnt     = bub_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Vector-table bench for fetch_ctrl, plus a narrow-counter copy
//            sharing the same inputs to exercise bubble_cnt saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.WIDTH(32), .CNTW(16)) bus1();
    fetch_ctrl_if #(.WIDTH(32), .CNTW(2))  bus2();

    assign bus2.imem_ready = bus1.imem_ready;
    assign bus2.stall_dec  = bus1.stall_dec;
    assign bus2.br_taken   = bus1.br_taken;
    assign bus2.br_target  = bus1.br_target;

    fetch_ctrl #(.WIDTH(32), .BOOT_CYC(2), .WAIT_MAX(15), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master));
    fetch_ctrl #(.WIDTH(32), .BOOT_CYC(2), .WAIT_MAX(15), .CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.master));

    typedef struct {
        string       name;
        logic        rst_n, rdy, stl, br;
        logic [31:0] tgt;
        logic        req_chk, req;
        logic [5:0]  ctl;   // {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, fetch_err}
        logic [31:0] ba;
        int          bub;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input string n, input logic r, input logic rdy, input logic stl,
                       input logic br, input logic [31:0] tgt, input logic rc, input logic rq,
                       input logic [5:0] ctl, input logic [31:0] ba, input int bub);
        vec_t v;
        v.name = n; v.rst_n = r; v.rdy = rdy; v.stl = stl; v.br = br; v.tgt = tgt;
        v.req_chk = rc; v.req = rq; v.ctl = ctl; v.ba = ba; v.bub = bub;
        tbl.push_back(v);
    endtask

    task automatic check_one();
        vec_t        e;
        logic [5:0]  got;
        int          exp2;
        e   = sb.pop_front();
        got = {bus1.pc_en, bus1.pc_sel, bus1.ifid_en, bus1.ifid_flush,
               bus1.idex_flush, bus1.fetch_err};
        checks++;
        if (got !== e.ctl || bus1.branch_address !== e.ba ||
            int'(bus1.bubble_cnt) != e.bub || (e.req_chk && bus1.imem_req !== e.req)) begin
            errors++;
            $display("FAIL %s: ctl=%b ba=%h bub=%0d req=%b, want ctl=%b ba=%h bub=%0d req=%b",
                     e.name, got, bus1.branch_address, bus1.bubble_cnt, bus1.imem_req,
                     e.ctl, e.ba, e.bub, e.req_chk ? e.req : bus1.imem_req);
        end
        exp2 = (e.bub > 3) ? 3 : e.bub;
        checks++;
        if (int'(bus2.bubble_cnt) != exp2) begin
            errors++;
            $display("FAIL %s/sat: bubble_cnt=%0d, want %0d", e.name, bus2.bubble_cnt, exp2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus1.imem_ready = 1'b0;
        bus1.stall_dec  = 1'b0;
        bus1.br_taken   = 1'b0;
        bus1.br_target  = '0;

        //   name       rst rdy stl br  target        rc rq  ctl        ba            bub
        add("reset",    0,  1,  0,  0,  32'h0,        1, 0, 6'b000000, 32'h0,        0);
        add("boot0",    1,  1,  0,  0,  32'h0,        1, 0, 6'b000100, 32'h0,        0);
        add("boot1",    1,  1,  0,  1,  32'h77,       1, 0, 6'b000100, 32'h0,        1);
        add("fetch0",   1,  1,  0,  0,  32'h0,        0, 0, 6'b101000, 32'h0,        2);
        add("fetch1",   1,  1,  0,  0,  32'h0,        0, 0, 6'b101000, 32'h0,        2);
        add("br40",     1,  1,  0,  1,  32'h40,       1, 0, 6'b000110, 32'h0,        2);
        add("redir40",  1,  1,  0,  0,  32'h0,        1, 0, 6'b111100, 32'h40,       3);
        add("postredir",1,  1,  0,  0,  32'h0,        0, 0, 6'b101000, 32'h40,       4);
        for (int i = 0; i < 3; i++)
            add("wait3",1,  0,  0,  0,  32'h0,        0, 0, 6'b001100, 32'h40,       4 + i);
        add("waitdone", 1,  1,  0,  0,  32'h0,        0, 0, 6'b101000, 32'h40,       7);
        for (int i = 0; i < 4; i++)
            add("stall4",1, 1,  1,  0,  32'h0,        1, 1, 6'b000000, 32'h40,       7);
        add("unstall",  1,  1,  0,  0,  32'h0,        0, 0, 6'b101000, 32'h40,       7);
        add("stall_br", 1,  1,  1,  1,  32'h12345678, 1, 0, 6'b000110, 32'h40,       7);
        add("redir_stl",1,  1,  1,  0,  32'h0,        1, 0, 6'b111100, 32'h12345678, 8);
        add("br100",    1,  1,  0,  1,  32'h100,      1, 0, 6'b000110, 32'h12345678, 9);
        add("retrig",   1,  1,  0,  1,  32'h200,      1, 0, 6'b111110, 32'h100,      10);
        add("redir200", 1,  1,  0,  0,  32'h0,        1, 0, 6'b111100, 32'h200,      11);
        add("fetch2",   1,  1,  0,  0,  32'h0,        0, 0, 6'b101000, 32'h200,      12);
        // Timeout run: 7 waits, a stall that freezes the count, then 8 more.
        for (int i = 0; i < 7; i++)
            add("to_wait",1, 0, 0,  0,  32'h0,        0, 0, 6'b001100, 32'h200,      12 + i);
        for (int i = 0; i < 2; i++)
            add("to_stall",1,0, 1,  0,  32'h0,        1, 1, 6'b000000, 32'h200,      19);
        for (int i = 7; i < 15; i++)
            add("to_wait",1, 0, 0,  0,  32'h0,        0, 0, 6'b001100, 32'h200,      12 + i);
        add("halt_br",  1,  1,  0,  1,  32'hDEAD,     1, 0, 6'b000101, 32'h200,      27);
        add("halt_stl", 1,  1,  1,  0,  32'h0,        1, 0, 6'b000101, 32'h200,      28);
        add("rst_pulse",0,  1,  0,  0,  32'h0,        1, 0, 6'b000000, 32'h0,        0);
        add("reboot0",  1,  1,  0,  0,  32'h0,        1, 0, 6'b000100, 32'h0,        0);
        add("reboot1",  1,  1,  0,  0,  32'h0,        1, 0, 6'b000100, 32'h0,        1);
        add("refetch",  1,  1,  0,  0,  32'h0,        0, 0, 6'b101000, 32'h0,        2);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n           = tbl[i].rst_n;
            bus1.imem_ready = tbl[i].rdy;
            bus1.stall_dec  = tbl[i].stl;
            bus1.br_taken   = tbl[i].br;
            bus1.br_target  = tbl[i].tgt;
            sb.push_back(tbl[i]);
            #4;
            check_one();
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
